// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch interface.
// Ports (signals):
//   imem_req   fetch request, held with a stable imem_addr until imem_ack
//   imem_addr  word-aligned fetch address
//   imem_ack   response valid; may assert in the same cycle as imem_req
//   imem_rdata instruction word, valid with imem_ack
// The master modport is used by the fetch unit, and the slave modport by the memory.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage. It owns the PC, issues requests to instruction memory and
// delivers {instr, pc, pc+4} to decode. A redirect from branch_ctrl flushes the stage.
// A 1-entry skid register catches a response that arrives while decode is stalled.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   branch_f       next-PC select: 10 branch_target, 01 alu_result (JALR), 00/11 sequential
//   branch_target  PC+imm target
//   alu_result     JALR target
//   stall          decode cannot accept if_* this cycle
//   imem           instruction-memory interface (master side)
//   if_valid       if_instr/if_pc/if_pc4 hold a live instruction
//   if_instr       fetched instruction
//   if_pc, if_pc4  address of if_instr and that address + 4
//   flush          one-cycle pulse after a redirect is taken
module pc_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             branch_f,
  input  logic [XLEN-1:0]        branch_target,
  input  logic [XLEN-1:0]        alu_result,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [XLEN-1:0]        if_pc,
  output logic [XLEN-1:0]        if_pc4,
  output logic                   flush
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state;
  logic [XLEN-1:0] pc;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            drop;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            slot_free;
  logic            ack_live;
  logic [XLEN-1:0] pc_inc;

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = fetch_addr;

  assign redirect   = (branch_f == 2'b10) || (branch_f == 2'b01);
  assign target_raw = (branch_f == 2'b01) ? alu_result : branch_target;
  // Targets are silently word aligned; misaligned targets do not trap.
  assign target     = target_raw & {{(XLEN-2){1'b1}}, 2'b00};
  assign slot_free  = !if_valid || !stall;
  // A response only counts while a request is outstanding and not marked stale.
  assign ack_live   = (state == StBusy) && imem.imem_ack && !drop;
  assign pc_inc     = pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      fetch_req  <= 1'b0;
      fetch_addr <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      drop       <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      if_pc4     <= '0;
      flush      <= 1'b0;
    end else begin
      flush <= redirect;
      if (redirect) begin
        pc         <= target;
        if_valid   <= 1'b0;
        if_instr   <= NOP_INSTR;
        skid_valid <= 1'b0;
        if ((state == StBusy) && !imem.imem_ack) begin
          // Request must complete on the bus first; its data is thrown away.
          drop <= 1'b1;
        end else begin
          // Nothing outstanding (or this cycle's ack is discarded): fetch target now.
          drop       <= 1'b0;
          state      <= StBusy;
          fetch_req  <= 1'b1;
          fetch_addr <= target;
        end
      end else begin
        // Output slot / skid update.
        if (ack_live) begin
          if (slot_free) begin
            if_valid <= 1'b1;
            if_instr <= imem.imem_rdata;
            if_pc    <= pc;
            if_pc4   <= pc_inc;
          end else begin
            skid_valid <= 1'b1;
            skid_instr <= imem.imem_rdata;
            skid_pc    <= pc;
          end
        end else if (skid_valid && slot_free) begin
          if_valid   <= 1'b1;
          if_instr   <= skid_instr;
          if_pc      <= skid_pc;
          if_pc4     <= skid_pc + XLEN'(4);
          skid_valid <= 1'b0;
        end else if (slot_free) begin
          if_valid <= 1'b0;
        end

        // Request FSM.
        case (state)
          StIdle: begin
            if (!skid_valid && !drop) begin
              state      <= StBusy;
              fetch_req  <= 1'b1;
              fetch_addr <= pc;
            end
          end
          StBusy: begin
            if (imem.imem_ack) begin
              if (drop) begin
                // Stale response retired; pc already holds the redirect target.
                drop       <= 1'b0;
                fetch_addr <= pc;
              end else begin
                pc <= pc_inc;
                if (slot_free) begin
                  fetch_addr <= pc_inc;
                end else begin
                  // Response went to the skid; pause until it drains.
                  state     <= StIdle;
                  fetch_req <= 1'b0;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  branch_f = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] alu_result = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        flush;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit_if #(.XLEN(32)) imem ();

  pc_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .branch_f(branch_f),
    .branch_target(branch_target),
    .alu_result(alu_result),
    .stall(stall),
    .imem(imem),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc4(if_pc4),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Memory model: data = address, ack after 'lat' waiting cycles (0 = same cycle).
  int unsigned lat = 0;
  int unsigned cnt;
  assign imem.imem_ack   = imem.imem_req && (cnt >= lat);
  assign imem.imem_rdata = imem.imem_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (imem.imem_req && !imem.imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, if_valid, if_instr, if_pc, if_pc4, flush} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h flush=%b",
               imem.imem_req, imem.imem_addr, if_valid, if_instr, if_pc, if_pc4, flush);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    lat = 0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL seq_first_req: valid=%b req=%b addr=%h, want 0 1 00000000",
               if_valid, imem.imem_req, imem.imem_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({if_valid, if_instr, if_pc, if_pc4} !== {1'b1, e, e, e + 32'd4})
        $display("FAIL seq_stream[%0d]: valid=%b instr=%h pc=%h pc4=%h, want pc %h", i,
                 if_valid, if_instr, if_pc, if_pc4, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_busy();
    lat = 3;
    @(negedge clk);
    n_checks++;
    if ({imem.imem_req, imem.imem_ack} !== 2'b10)
      $display("FAIL rst_busy_pre: req=%b ack=%b, want 1 0", imem.imem_req, imem.imem_ack);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({imem.imem_req, imem.imem_addr, if_valid, if_instr, if_pc, if_pc4, flush} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0})
      $display("FAIL rst_busy_async: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h flush=%b",
               imem.imem_req, imem.imem_addr, if_valid, if_instr, if_pc, if_pc4, flush);
    else n_pass++;
    @(negedge clk);
    lat = 0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL rst_busy_restart: valid=%b req=%b addr=%h, want 0 1 00000000",
               if_valid, imem.imem_req, imem.imem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0})
      $display("FAIL rst_busy_first: valid=%b pc=%h, want 1 00000000", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_branch_drop();
    logic found = 1'b0;
    logic addr_seen = 1'b0;
    logic [31:0] e;
    lat = 2;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = imem.imem_req && (imem.imem_addr == 32'h10) && !imem.imem_ack;
    end
    n_checks++;
    if (!found) $display("FAIL br_wait_0x10: req=%b addr=%h, want outstanding 0x10",
                         imem.imem_req, imem.imem_addr);
    else n_pass++;
    branch_f = 2'b10;
    branch_target = 32'h40;
    @(negedge clk);
    branch_f = 2'b00;
    n_checks++;
    if ({flush, if_valid, if_instr} !== {1'b1, 1'b0, NOP})
      $display("FAIL br_flush: flush=%b valid=%b instr=%h, want 1 0 %h",
               flush, if_valid, if_instr, NOP);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b0) $display("FAIL br_flush_pulse: flush=%b, want 0", flush);
    else n_pass++;
    exp_q = {};
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + 32'(i * 4));
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (!addr_seen && imem.imem_req && imem.imem_addr != 32'h10) begin
        addr_seen = 1'b1;
        n_checks++;
        if (imem.imem_addr !== 32'h40)
          $display("FAIL br_next_addr: addr=%h, want 00000040", imem.imem_addr);
        else n_pass++;
      end
      if (if_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({if_instr, if_pc, if_pc4} !== {e, e, e + 32'd4})
          $display("FAIL br_stream: instr=%h pc=%h pc4=%h, want pc %h", if_instr, if_pc, if_pc4, e);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL br_timeout: %0d left, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_jalr();
    logic [31:0] e;
    lat = 0;
    repeat (3) @(negedge clk);
    branch_f = 2'b01;
    alu_result = 32'h103;
    branch_target = 32'h777;
    @(negedge clk);
    branch_f = 2'b11;
    n_checks++;
    if ({flush, imem.imem_req, imem.imem_addr, if_valid} !== {1'b1, 1'b1, 32'h100, 1'b0})
      $display("FAIL jalr_redirect: flush=%b req=%b addr=%h valid=%b, want 1 1 00000100 0",
               flush, imem.imem_req, imem.imem_addr, if_valid);
    else n_pass++;
    exp_q = {};
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({flush, if_valid, if_instr, if_pc, if_pc4} !== {1'b0, 1'b1, e, e, e + 32'd4})
        $display("FAIL jalr_seq11[%0d]: flush=%b valid=%b instr=%h pc=%h, want 0 1 pc %h", i,
                 flush, if_valid, if_instr, if_pc, e);
      else n_pass++;
    end
    branch_f = 2'b00;
  endtask

  task automatic test_stall_skid();
    logic [31:0] e;
    logic prev_stall = 1'b0;
    lat = 0;
    branch_f = 2'b10;
    branch_target = 32'h200;
    @(negedge clk);
    branch_f = 2'b00;
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        // Stalled: head of scoreboard must be held and no new fetch issued.
        n_checks++;
        if ({if_valid, imem.imem_req, if_pc} !== {1'b1, 1'b0, exp_q[0]})
          $display("FAIL stall_hold c%0d: valid=%b req=%b pc=%h, want 1 0 %h", c,
                   if_valid, imem.imem_req, if_pc, exp_q[0]);
        else n_pass++;
      end
      stall = (c >= 2 && c < 5);
      prev_stall = stall;
      if (if_valid && !stall) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({if_instr, if_pc, if_pc4} !== {e, e, e + 32'd4})
          $display("FAIL stall_order: instr=%h pc=%h pc4=%h, want pc %h", if_instr, if_pc, if_pc4, e);
        else n_pass++;
      end
    end
    stall = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stall_timeout: %0d left, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    lat = 0;
    branch_f = 2'b10;
    branch_target = 32'hFFFF_FFFA;
    @(negedge clk);
    branch_f = 2'b00;
    n_checks++;
    if ({flush, imem.imem_addr} !== {1'b1, 32'hFFFF_FFF8})
      $display("FAIL wrap_redirect: flush=%b addr=%h, want 1 fffffff8", flush, imem.imem_addr);
    else n_pass++;
    exp_q = {};
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({if_valid, if_instr, if_pc, if_pc4} !== {1'b1, e, e, e + 32'd4})
        $display("FAIL wrap_stream[%0d]: valid=%b instr=%h pc=%h pc4=%h, want pc %h", i,
                 if_valid, if_instr, if_pc, if_pc4, e);
      else n_pass++;
      if (e == 32'hFFFF_FFFC) begin
        n_checks++;
        if ({if_pc4, imem.imem_addr} !== {32'h0, 32'h0})
          $display("FAIL wrap_pc4: pc4=%h addr=%h, want 00000000 00000000", if_pc4, imem.imem_addr);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_reset_busy();
    test_branch_drop();
    test_jalr();
    test_stall_skid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
